dual_syn_ram_be: RTL and testbench

DUAL_SYN_RAM_BE -- requirements
Module: dual_syn_ram_be

---
 rtl/dual_syn_ram_be.sv | 140 ++++++++++++++
 tb/tb_dual_syn_ram_be.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_syn_ram_be.sv
// Purpose : dual-port (1W/1R) synchronous RAM with byte-lane write enables and a
//           power-up/reset clear sequence that zeroes every word before use.
// Latency : read data registered, valid one cycle after re; busy for DEPTH cycles after reset;
//           no backpressure: requests are simply dropped while busy.
// Option  : define DUAL_SYN_RAM_BYPASS_EN for write-first collision data (default read-first).
module dual_syn_ram_be #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_BUS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_BUS-1:0]   wr_addr,
    input  logic [WIDTH-1:0]      din,
    input  logic [WIDTH/8-1:0]    be,
    input  logic                  re,
    input  logic [ADDR_BUS-1:0]   rd_addr,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_vld,
    output logic                  busy
);

    localparam int NB = WIDTH / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_BUS-1:0]   r_clr_cnt;
    logic [ADDR_BUS-1:0]   w_clr_cnt_nxt;
    logic                  w_clr_last;

    logic [WIDTH-1:0]      r_mem [0:DEPTH-1];
    logic [WIDTH-1:0]      r_dout;
    logic                  r_dout_vld;

    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_hit;
    logic                  w_rd_en;
    logic [WIDTH-1:0]      w_rd_data;

    // Addresses at or beyond DEPTH are decoded as holes (writes dropped, reads return zero).
    assign w_wr_in_range = (32'(wr_addr) < DEPTH);
    assign w_rd_in_range = (32'(rd_addr) < DEPTH);
    assign w_clr_last    = (32'(r_clr_cnt) == (DEPTH - 1));

    // User traffic is only honoured once the clear sweep has finished.
    assign w_wr_hit = (r_state == ST_READY) && we && w_wr_in_range;
    assign w_rd_en  = (r_state == ST_READY) && re;

    assign busy     = (r_state == ST_CLEAR);
    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;

    // FSM state and clear-address register; reset restarts the sweep from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    // Next-state: sweep clr_cnt over every word, leave CLEAR on the edge that clears the last one.
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        case (r_state)
            ST_CLEAR: begin
                if (w_clr_last) begin
                    w_state_nxt   = ST_READY;
                    w_clr_cnt_nxt = '0;
                end else begin
                    w_clr_cnt_nxt = r_clr_cnt + ADDR_BUS'(1);
                end
            end
            ST_READY: begin
                w_state_nxt   = ST_READY;
                w_clr_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt   = ST_CLEAR;
                w_clr_cnt_nxt = '0;
            end
        endcase
    end

    // Memory array: zeroing during CLEAR, byte-lane masked writes during READY, untouched in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_hit) begin
                for (int k = 0; k < NB; k++) begin
                    if (be[k]) begin
                        r_mem[wr_addr][8*k +: 8] <= din[8*k +: 8];
                    end
                end
            end
        end
    end

    // Read mux: zero for holes; on a same-address collision optionally forward enabled din lanes.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_in_range) begin
            w_rd_data = r_mem[rd_addr];
`ifdef DUAL_SYN_RAM_BYPASS_EN
            if (w_wr_hit && (wr_addr == rd_addr)) begin
                for (int k = 0; k < NB; k++) begin
                    if (be[k]) begin
                        w_rd_data[8*k +: 8] = din[8*k +: 8];
                    end
                end
            end
`endif
        end
    end

    // Registered read port: dout holds between reads, dout_vld pulses once per accepted read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout     <= '0;
            r_dout_vld <= 1'b0;
        end else begin
            r_dout_vld <= w_rd_en;
            if (w_rd_en) begin
                r_dout <= w_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_dual_syn_ram_be.sv
// Purpose : directed bench for dual_syn_ram_be (DEPTH=16 instance and a DEPTH=12 instance).
// Latency : each vector is driven before an edge and its read result sampled 1 ns after it.
// Option  : expected collision data follows DUAL_SYN_RAM_BYPASS_EN when it is defined.
module tb_dual_syn_ram_be;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DEPTH=16 instance
    logic        a_rst, a_we, a_re;
    logic [3:0]  a_wa, a_ra, a_be;
    logic [31:0] a_din, a_dout;
    logic        a_dout_vld, a_busy;

    // DEPTH=12 instance
    logic        b_rst, b_we, b_re;
    logic [3:0]  b_wa, b_ra, b_be;
    logic [31:0] b_din, b_dout;
    logic        b_dout_vld, b_busy;

    dual_syn_ram_be #(.WIDTH(32), .DEPTH(16), .ADDR_BUS(4)) u_dut (
        .clk(clk), .rst(a_rst), .we(a_we), .wr_addr(a_wa), .din(a_din), .be(a_be),
        .re(a_re), .rd_addr(a_ra), .dout(a_dout), .dout_vld(a_dout_vld), .busy(a_busy)
    );

    dual_syn_ram_be #(.WIDTH(32), .DEPTH(12), .ADDR_BUS(4)) u_dut12 (
        .clk(clk), .rst(b_rst), .we(b_we), .wr_addr(b_wa), .din(b_din), .be(b_be),
        .re(b_re), .rd_addr(b_ra), .dout(b_dout), .dout_vld(b_dout_vld), .busy(b_busy)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] din;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic        exp_vld;
        logic [31:0] exp_dout;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Count busy cycles on the 16-deep instance; optionally poke we/re mid-sweep.
    task automatic count_busy_a(input bit pulse, output int n);
        n = 0;
        while (a_busy && n < 64) begin
            if (pulse) begin
                check($sformatf("busy_vld[%0d]", n), 32'(a_dout_vld), 32'd0);
                check($sformatf("busy_dout[%0d]", n), a_dout, 32'd0);
                if (n == 10) begin
                    a_we = 1'b1; a_wa = 4'd2; a_din = 32'hFFFF_FFFF; a_be = 4'hF;
                    a_re = 1'b1; a_ra = 4'd3;
                end else if (n == 11) begin
                    a_we = 1'b0; a_re = 1'b0;
                end
            end
            n++;
            @(posedge clk); #1;
        end
        a_we = 1'b0; a_re = 1'b0;
    endtask

    task automatic count_busy_b(output int n);
        n = 0;
        while (b_busy && n < 64) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic step_a(input logic we, input logic [3:0] wa, input logic [31:0] din,
                          input logic [3:0] be, input logic re, input logic [3:0] ra);
        a_we = we; a_wa = wa; a_din = din; a_be = be; a_re = re; a_ra = ra;
        @(posedge clk); #1;
        a_we = 1'b0; a_re = 1'b0;
    endtask

    task automatic step_b(input logic we, input logic [3:0] wa, input logic [31:0] din,
                          input logic [3:0] be, input logic re, input logic [3:0] ra);
        b_we = we; b_wa = wa; b_din = din; b_be = be; b_re = re; b_ra = ra;
        @(posedge clk); #1;
        b_we = 1'b0; b_re = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] exp_col7;
        logic [31:0] exp_col5;

`ifdef DUAL_SYN_RAM_BYPASS_EN
        exp_col7 = 32'hFF34_5678;
        exp_col5 = 32'hDEAD_BEEF;
`else
        exp_col7 = 32'h1234_5678;
        exp_col5 = 32'h0000_0000;
`endif
        //           we    wa     din            be      re    ra     vld   dout
        vecs[0]  = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b1, 4'd0,  1'b1, 32'h0};
        vecs[1]  = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b1, 4'd15, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 4'd3,  32'hAABBCCDD,  4'hF,   1'b0, 4'd0,  1'b0, 32'h0};
        vecs[3]  = '{1'b1, 4'd3,  32'h11223344,  4'b0101,1'b0, 4'd0,  1'b0, 32'h0};
        vecs[4]  = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b1, 4'd3,  1'b1, 32'hAA22CC44};
        vecs[5]  = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b0, 4'd3,  1'b0, 32'hAA22CC44};
        vecs[6]  = '{1'b1, 4'd7,  32'h12345678,  4'hF,   1'b1, 4'd3,  1'b1, 32'hAA22CC44};
        vecs[7]  = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b1, 4'd7,  1'b1, 32'h12345678};
        vecs[8]  = '{1'b1, 4'd7,  32'hFFFFFFFF,  4'h0,   1'b0, 4'd0,  1'b0, 32'h12345678};
        vecs[9]  = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b1, 4'd7,  1'b1, 32'h12345678};
        vecs[10] = '{1'b1, 4'd7,  32'hFF000000,  4'b1000,1'b1, 4'd7,  1'b1, exp_col7};
        vecs[11] = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b1, 4'd7,  1'b1, 32'hFF345678};
        vecs[12] = '{1'b1, 4'd5,  32'hDEADBEEF,  4'hF,   1'b1, 4'd5,  1'b1, exp_col5};
        vecs[13] = '{1'b0, 4'd0,  32'h0,         4'h0,   1'b1, 4'd5,  1'b1, 32'hDEADBEEF};

        a_rst = 1'b1; a_we = 1'b0; a_re = 1'b0; a_wa = '0; a_ra = '0; a_din = '0; a_be = '0;
        b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_wa = '0; b_ra = '0; b_din = '0; b_be = '0;

        // One-cycle reset, then the power-up sweep.
        @(posedge clk); #1;
        check("rst_busy", 32'(a_busy), 32'd1);
        check("rst_vld", 32'(a_dout_vld), 32'd0);
        check("rst_dout", a_dout, 32'd0);
        a_rst = 1'b0;
        count_busy_a(1'b0, n);
        check("busy_len", n, 32'd16);

        // Table of single-cycle operations, one result sampled per vector.
        for (int i = 0; i < NVEC; i++) begin
            a_we = vecs[i].we; a_wa = vecs[i].wa; a_din = vecs[i].din; a_be = vecs[i].be;
            a_re = vecs[i].re; a_ra = vecs[i].ra;
            @(posedge clk); #1;
            check($sformatf("vec%0d_vld", i), 32'(a_dout_vld), 32'(vecs[i].exp_vld));
            check($sformatf("vec%0d_dout", i), a_dout, vecs[i].exp_dout);
        end
        a_we = 1'b0; a_re = 1'b0;

        // Reset in the middle of the sweep (clear cycle 7), then requests while busy.
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
        end
        check("midclr_busy", 32'(a_busy), 32'd1);
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        check("midclr_rst_dout", a_dout, 32'd0);
        count_busy_a(1'b1, n);
        check("midclr_busy_len", n, 32'd16);
        step_a(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2);
        check("midclr_rd2_vld", 32'(a_dout_vld), 32'd1);
        check("midclr_rd2", a_dout, 32'd0);
        step_a(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3);
        check("midclr_rd3", a_dout, 32'd0);
        step_a(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7);
        check("midclr_rd7", a_dout, 32'd0);

        // DEPTH=12 instance: sweep length and the address holes at 12 and 13.
        b_rst = 1'b0;
        count_busy_b(n);
        check("d12_busy_len", n, 32'd12);
        for (int i = 0; i < 12; i++) begin
            step_b(1'b1, 4'(i), 32'h0101_0101 * 32'(i + 1), 4'hF, 1'b0, 4'd0);
        end
        step_b(1'b1, 4'd13, 32'h0000_0055, 4'hF, 1'b0, 4'd0);
        step_b(1'b1, 4'd12, 32'hFFFF_FFFF, 4'hF, 1'b0, 4'd0);
        step_b(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd13);
        check("d12_rd13_vld", 32'(b_dout_vld), 32'd1);
        check("d12_rd13", b_dout, 32'd0);
        step_b(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd12);
        check("d12_rd12", b_dout, 32'd0);
        for (int i = 0; i < 12; i++) begin
            step_b(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'(i));
            check($sformatf("d12_rd%0d", i), b_dout, 32'h0101_0101 * 32'(i + 1));
        end
        @(posedge clk); #1;
        check("d12_idle_vld", 32'(b_dout_vld), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
